// File: rtl/imem_pipe.sv
// Instruction memory with a handshaked read pipeline (latency 1 or 2), a byte-enabled
// load port, explicit address-fault reporting and a post-reset zero-fill engine.
module imem_pipe #(
  parameter int AW           = 32,
  parameter int IW           = 32,
  parameter int DEPTH        = 16,
  parameter int LAT          = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_stall,
  output logic            rd_ready,
  output logic            rd_valid,
  output logic [IW-1:0]   rd_inst,
  output logic [1:0]      rd_fault,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [IW-1:0]   ld_data,
  input  logic [IW/8-1:0] ld_be,
  output logic            ld_ready,
  output logic            ld_err,
  output logic            busy
);

  localparam int          WORDS = 2**(DEPTH-2);
  localparam int unsigned NB    = IW/8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state;
  logic [DEPTH-3:0] clr_cnt;
  logic [IW-1:0]    mem [WORDS];

  logic             rd_acc;
  logic [DEPTH-3:0] rd_idx;
  logic [1:0]       rd_fault_c;
  logic [IW-1:0]    rd_data_c;
  logic             ld_acc;
  logic             ld_bad;
  logic [DEPTH-3:0] ld_idx;

  logic             st_valid;
  logic [IW-1:0]    st_inst;
  logic [1:0]       st_fault;

  assign busy     = (state == CLEAR);
  assign rd_ready = (state == READY) && !rd_stall;
  assign ld_ready = (state == READY);

  assign rd_acc     = rd_req && rd_ready;
  assign rd_idx     = rd_addr[DEPTH-1:2];
  assign rd_fault_c = {|rd_addr[AW-1:DEPTH], |rd_addr[1:0]};
  // Faulting reads never touch the array; they carry a zero word.
  assign rd_data_c  = (|rd_fault_c) ? '0 : mem[rd_idx];

  assign ld_acc = ld_en && ld_ready;
  assign ld_bad = (|ld_addr[AW-1:DEPTH]) || (|ld_addr[1:0]);
  assign ld_idx = ld_addr[DEPTH-1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= (CLEAR_ON_RST != 0) ? CLEAR : READY;
      clr_cnt <= '0;
      ld_err  <= 1'b0;
    end else begin
      ld_err <= ld_acc && ld_bad;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == '1)
          state <= READY;
      end
    end
  end

  // Array reads use pre-edge contents, so a same-cycle load is seen only by later reads.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (ld_acc && !ld_bad) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (ld_be[i])
          mem[ld_idx][8*i +: 8] <= ld_data[8*i +: 8];
      end
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic          s1_valid;
      logic [IW-1:0] s1_inst;
      logic [1:0]    s1_fault;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1_valid <= 1'b0;
          s1_inst  <= '0;
          s1_fault <= '0;
        end else if (!rd_stall) begin
          s1_valid <= rd_acc;
          s1_inst  <= rd_data_c;
          s1_fault <= rd_fault_c;
        end
      end

      assign st_valid = s1_valid;
      assign st_inst  = s1_inst;
      assign st_fault = s1_fault;
    end else begin : g_lat1
      assign st_valid = rd_acc;
      assign st_inst  = rd_data_c;
      assign st_fault = rd_fault_c;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_inst  <= '0;
      rd_fault <= '0;
    end else if (!rd_stall) begin
      rd_valid <= st_valid;
      if (st_valid) begin
        rd_inst  <= st_inst;
        rd_fault <= st_fault;
      end
    end
  end

endmodule

// File: tb/tb_imem_pipe.sv
// Drives a latency-1 and a latency-2 instance with shared stimulus and checks both
// against a queue-based reference model of the memory and its read latency.
module tb_imem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_stall;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [3:0]  ld_be;

  logic        rdy [2];
  logic        vld [2];
  logic [31:0] inst [2];
  logic [1:0]  flt [2];
  logic        ldr [2];
  logic        lde [2];
  logic        bsy [2];

  always #5 clk = ~clk;

  imem_pipe #(.AW(32), .IW(32), .DEPTH(8), .LAT(1), .CLEAR_ON_RST(1)) u_lat1 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_stall(rd_stall),
    .rd_ready(rdy[0]), .rd_valid(vld[0]), .rd_inst(inst[0]), .rd_fault(flt[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
    .ld_ready(ldr[0]), .ld_err(lde[0]), .busy(bsy[0])
  );

  imem_pipe #(.AW(32), .IW(32), .DEPTH(8), .LAT(2), .CLEAR_ON_RST(1)) u_lat2 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_stall(rd_stall),
    .rd_ready(rdy[1]), .rd_valid(vld[1]), .rd_inst(inst[1]), .rd_fault(flt[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_be(ld_be),
    .ld_ready(ldr[1]), .ld_err(lde[1]), .busy(bsy[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: word array plus a list of outstanding reads, each carrying the
  // number of unstalled edges left before it shows up at each instance's outputs.
  typedef struct {
    int          r0;
    int          r1;
    logic [31:0] inst;
    logic [1:0]  flt;
  } ent_t;

  logic [31:0] mmem [64];
  ent_t        pq [$];
  int          busy_left;
  logic        ev [2];
  logic [31:0] ei [2];
  logic [1:0]  ef [2];
  logic        eerr;

  function automatic logic [1:0] fault_of(input logic [31:0] a);
    return {a >= 32'd256, a % 4 != 0};
  endfunction

  task automatic model_reset();
    pq.delete();
    busy_left = 64;
    eerr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ev[d] = 1'b0;
      ei[d] = '0;
      ef[d] = '0;
    end
    for (int w = 0; w < 64; w++) mmem[w] = '0;
  endtask

  task automatic model_edge();
    logic racc;
    logic lacc;
    ent_t e;
    racc = rd_req && !rd_stall && (busy_left == 0);
    lacc = ld_en && (busy_left == 0);
    if (racc) begin
      e.flt  = fault_of(rd_addr);
      e.inst = (e.flt != 0) ? 32'h0 : mmem[rd_addr / 4 % 64];
      e.r0   = 1;
      e.r1   = 2;
      pq.push_back(e);
    end
    if (!rd_stall) begin
      ev[0] = 1'b0;
      ev[1] = 1'b0;
      foreach (pq[k]) begin
        if (pq[k].r0 > 0) begin
          pq[k].r0 = pq[k].r0 - 1;
          if (pq[k].r0 == 0) begin ev[0] = 1'b1; ei[0] = pq[k].inst; ef[0] = pq[k].flt; end
        end
        if (pq[k].r1 > 0) begin
          pq[k].r1 = pq[k].r1 - 1;
          if (pq[k].r1 == 0) begin ev[1] = 1'b1; ei[1] = pq[k].inst; ef[1] = pq[k].flt; end
        end
      end
      while (pq.size() > 0 && pq[0].r0 == 0 && pq[0].r1 == 0) void'(pq.pop_front());
    end
    eerr = lacc && (fault_of(ld_addr) != 0);
    if (lacc && fault_of(ld_addr) == 0) begin
      for (int b = 0; b < 4; b++)
        if (ld_be[b]) mmem[ld_addr / 4 % 64][8*b +: 8] = ld_data[8*b +: 8];
    end
    if (busy_left > 0) busy_left--;
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy%0d", d+1),     bsy[d], busy_left > 0);
      chk($sformatf("rd_ready%0d", d+1), rdy[d], (busy_left == 0) && !rd_stall);
      chk($sformatf("ld_ready%0d", d+1), ldr[d], busy_left == 0);
      chk($sformatf("ld_err%0d", d+1),   lde[d], eerr);
      chk($sformatf("rd_valid%0d", d+1), vld[d], ev[d]);
      if (ev[d]) begin
        chk($sformatf("rd_inst%0d", d+1),  inst[d], ei[d]);
        chk($sformatf("rd_fault%0d", d+1), flt[d], ef[d]);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare();
  endtask

  task automatic set_rd(input logic r, input logic [31:0] a, input logic s);
    rd_req = r; rd_addr = a; rd_stall = s;
  endtask

  task automatic set_ld(input logic e, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    ld_en = e; ld_addr = a; ld_data = d; ld_be = be;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
      1:       return 32'h100 + $urandom_range(0, 63) * 4;
      2:       return $urandom;
      default: return $urandom_range(0, 15) * 4;
    endcase
  endfunction

  task automatic clear_run(input string tag);
    int nb;
    nb = bsy[0] ? 1 : 0;
    repeat (70) begin
      tick();
      if (bsy[0]) nb++;
    end
    chk(tag, nb, 64);
  endtask

  logic [31:0] res [$];

  initial begin
    rst = 1'b0;
    set_rd(1'b0, '0, 1'b0);
    set_ld(1'b0, '0, '0, '0);
    #1 rst = 1'b1;
    model_reset();
    #1 compare();
    chk("rst_valid", vld[0], 1'b0);
    chk("rst_busy", bsy[1], 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 compare();

    // Zero-fill, with a pending read that must not be accepted meanwhile
    set_rd(1'b1, 32'h0, 1'b0);
    clear_run("clear_len");
    set_rd(1'b1, 32'hFC, 1'b0); tick();
    chk("clr_rd_fc", inst[0], 32'h0);
    chk("clr_flt_fc", flt[0], 2'b00);
    set_rd(1'b0, 32'h0, 1'b0); tick(); tick();

    // Byte-enabled loads
    set_ld(1'b1, 32'h10, 32'hDEADBEEF, 4'hF); tick();
    set_ld(1'b1, 32'h10, 32'h00000011, 4'h1); tick();
    set_ld(1'b0, 32'h0, 32'h0, 4'h0);
    set_rd(1'b1, 32'h10, 1'b0); tick();
    chk("be_valid", vld[0], 1'b1);
    chk("be_inst", inst[0], 32'hDEADBE11);
    set_rd(1'b0, 32'h0, 1'b0); tick();
    chk("be_valid_drop", vld[0], 1'b0);
    chk("be_inst_l2", inst[1], 32'hDEADBE11);

    // Faults
    set_rd(1'b1, 32'h102, 1'b0); tick();
    chk("flt_102", flt[0], 2'b11);
    chk("flt_102_inst", inst[0], 32'h0);
    set_rd(1'b1, 32'h101, 1'b0); tick();
    chk("flt_101", flt[0], 2'b11);
    set_rd(1'b1, 32'h03, 1'b0); tick();
    chk("flt_003", flt[0], 2'b01);
    set_rd(1'b0, 32'h0, 1'b0);
    set_ld(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF); tick();
    chk("ld_err_pulse", lde[0], 1'b1);
    set_ld(1'b0, 32'h0, 32'h0, 4'h0); tick();
    chk("ld_err_end", lde[0], 1'b0);
    set_rd(1'b1, 32'h0, 1'b0); tick();
    chk("oor_ld_nowrite", inst[0], 32'h0);

    // Latency-2 stream with a three-cycle stall in the middle
    set_rd(1'b0, 32'h0, 1'b0);
    set_ld(1'b1, 32'h0, 32'hA0A0A0A0, 4'hF); tick();
    set_ld(1'b1, 32'h4, 32'hA4A4A4A4, 4'hF); tick();
    set_ld(1'b1, 32'h8, 32'hA8A8A8A8, 4'hF); tick();
    set_ld(1'b0, 32'h0, 32'h0, 4'h0); tick(); tick();
    res.delete();
    for (int s = 0; s < 9; s++) begin
      case (s)
        0:          set_rd(1'b1, 32'h0, 1'b0);
        1:          set_rd(1'b1, 32'h4, 1'b0);
        2, 3, 4:    set_rd(1'b1, 32'h8, 1'b1);
        5:          set_rd(1'b1, 32'h8, 1'b0);
        default:    set_rd(1'b0, 32'h0, 1'b0);
      endcase
      tick();
      if (!rd_stall && vld[1]) res.push_back(inst[1]);
    end
    chk("stall_count", res.size(), 3);
    if (res.size() == 3) begin
      chk("stall_res0", res[0], 32'hA0A0A0A0);
      chk("stall_res1", res[1], 32'hA4A4A4A4);
      chk("stall_res2", res[2], 32'hA8A8A8A8);
    end

    // Read-first collision
    set_ld(1'b1, 32'h20, 32'h1, 4'hF); tick();
    set_ld(1'b1, 32'h20, 32'h2, 4'hF);
    set_rd(1'b1, 32'h20, 1'b0); tick();
    chk("coll_old", inst[0], 32'h1);
    set_ld(1'b0, 32'h0, 32'h0, 4'h0); tick();
    chk("coll_new", inst[0], 32'h2);
    set_rd(1'b0, 32'h0, 1'b0); tick(); tick();

    // Reset with latency-2 reads in flight
    set_rd(1'b1, 32'h0, 1'b0); tick();
    set_rd(1'b1, 32'h4, 1'b0); tick();
    #1 rst = 1'b1;
    model_reset();
    #1 compare();
    chk("midrst_valid1", vld[0], 1'b0);
    chk("midrst_valid2", vld[1], 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 compare();
    clear_run("clear_len_again");

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      rd_req   = $urandom_range(0, 3) != 0;
      rd_addr  = rnd_addr();
      rd_stall = $urandom_range(0, 4) == 0;
      ld_en    = $urandom_range(0, 2) == 0;
      ld_addr  = rnd_addr();
      ld_data  = $urandom;
      ld_be    = 4'($urandom_range(0, 15));
      tick();
    end
    set_rd(1'b0, 32'h0, 1'b0);
    set_ld(1'b0, 32'h0, 32'h0, 4'h0);
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
